g15_power_sequencer: RTL
========================

Name: g15_power_sequencer

Overview:
- Synthesizable power-up sequencer for the G-15 core, replacing the hand-timed stimulus that drives the power-cycle controls and the GO switch.
- Steps through the following sequence: CLEAR, ~OP/OP, ATS timing-track load, NT transfer, ATS loader-block load, GO.
- All durations are parametrised in tick periods. The sequence has warm-start, skip-track-load and auto-GO modes, plus tape-wait timeout detection.
- Sits beside the timer block (tick source) and g15_top, driving the PWR_* and SW_GO inputs of g15_top.

Parameters:
- CNT_W, 16, width of the duration/timeout counter.
- CLEAR_TICKS, 150, ticks PWR_CLEAR is held high.
- NOOP_PRE_TICKS, 30, ticks ~OP is low before OP rises.
- OP_TICKS, 60, ticks PWR_OP is held high.
- NOOP_POST_TICKS, 30, ticks ~OP stays low after OP falls.
- SETTLE_TICKS, 120, idle gap used by every SETTLE state.
- ATS_TICKS, 30, ticks PWR_ATS is held high.
- NT_TICKS, 120, ticks PWR_NT is held high.
- TAPE_TIMEOUT_TICKS, 60000, maximum ticks spent waiting for tape read-in to finish.

Ports:
- CLOCK, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- tick, in, 1, one-CLOCK-wide timebase pulse (ms).
- start, in, 1, pulse that begins a sequence; ignored while busy.
- abort, in, 1, returns the block to IDLE from any state.
- mode_warm, in, 1, skip CLEAR; sampled on start.
- mode_skip_tt, in, 1, skip the timing-track load and NT transfer; sampled on start.
- mode_auto_go, in, 1, raise SW_GO at the end of the sequence; sampled on start.
- PL6_WAIT_FOR_TAPE, in, 1, asynchronous input from the reader; high while a tape block is being read.
- PWR_CLEAR, out, 1, CLEAR OC control.
- PWR_NO_CLEAR, out, 1, complement of PWR_CLEAR.
- PWR_OP, out, 1, OP control.
- PWR_NO_OP, out, 1, ~OP control.
- PWR_ATS, out, 1, ATS control.
- PWR_NT, out, 1, number-track transfer control.
- SW_GO, out, 1, typewriter GO switch.
- busy, out, 1, high in every state except IDLE, DONE and FAULT.
- done, out, 1, high in DONE.
- fault, out, 1, high in FAULT (tape timeout).
- state_dbg, out, 5, current state encoding.

Behaviour:
- Reset: the clock and reset are CLOCK and rst; rst is synchronous, active-high. On reset the block enters IDLE with these output values:
  - PWR_CLEAR=0, PWR_NO_CLEAR=1, PWR_OP=0, PWR_NO_OP=1, PWR_ATS=0, PWR_NT=0.
  - SW_GO=0, busy=0, done=0, fault=0, state_dbg=0.
  - Synchronizer flops and counter are cleared.
- All outputs are registered and decoded from the state register, so they change one CLOCK after the state transition.
- States and encodings: IDLE 0, CLEAR 1, NOOP_PRE 2, OP 3, NOOP_POST 4, SETTLE_A 5, ATS_TT 6, WAIT_TT 7, SETTLE_B 8, NT 9, SETTLE_C 10, ATS_LD 11, WAIT_LD 12, SETTLE_D 13, GO 14, DONE 15, FAULT 16.
- Output decode by state:
  - PWR_CLEAR=1 in CLEAR.
  - PWR_NO_OP=0 in NOOP_PRE, OP and NOOP_POST.
  - PWR_OP=1 in OP.
  - PWR_ATS=1 in ATS_TT and ATS_LD.
  - PWR_NT=1 in NT.
  - SW_GO=1 in GO and in DONE when entered via GO.
- Timed states: the counter loads the state's parameter on the entry edge. Ticks are counted from the cycle after entry; a tick on the entry cycle is ignored. The state exits on the edge following its Nth tick. A parameter value of 0 means the state is exited on the cycle after entry.
- Sequence: IDLE -> CLEAR -> NOOP_PRE -> OP -> NOOP_POST -> SETTLE_A -> ATS_TT -> WAIT_TT -> SETTLE_B -> NT -> SETTLE_C -> ATS_LD -> WAIT_LD -> SETTLE_D -> GO -> DONE.
- mode_warm=1: IDLE goes directly to NOOP_PRE.
- mode_skip_tt=1: SETTLE_A goes directly to ATS_LD.
- mode_auto_go=0: SETTLE_D goes to DONE with SW_GO=0.
- GO lasts one cycle, then DONE.
- Mode inputs are latched on the start edge; changes during a sequence are ignored.
- Tape wait:
  - PL6_WAIT_FOR_TAPE passes through a 2-flop synchronizer, then a registered falling-edge detector.
  - A falling edge sets an armed flag; the flag is cleared on entry to ATS_TT/ATS_LD.
  - A falling edge is honoured only from ATS entry onward, so a falling edge during ATS is retained.
  - WAIT_* exits on the cycle after the flag is set.
  - The counter loads TAPE_TIMEOUT_TICKS on WAIT entry; if it expires first, go to FAULT.
- DONE and FAULT hold until start (begins a new sequence; SW_GO drops on that edge) or abort. start is ignored in all other non-IDLE states.
- abort in any state: next edge gives IDLE with reset output values. Simultaneous abort and start: abort wins.
- Counter never wraps. It saturates at 0 until the state changes.

Test Plan:
- Parameters CLEAR=3, NOOP_PRE=2, OP=4, NOOP_POST=2, SETTLE=5, ATS=2, NT=3, TIMEOUT=50, all modes 0, tick every 4 CLOCKs:
  - Stimulus: start, with reader model pulsing PL6_WAIT_FOR_TAPE high 10 ticks after each ATS.
  - Required response: PWR_CLEAR high exactly 3 ticks, PWR_OP high exactly 4 ticks inside a ~OP-low window of 8 ticks, PWR_NT high 3 ticks, ends in DONE with state_dbg=15, busy=0 and SW_GO=0.
- Same parameters, mode_warm=1, mode_skip_tt=1, mode_auto_go=1:
  - Required response: PWR_CLEAR never rises, PWR_ATS pulses exactly once, PWR_NT never rises, SW_GO=1 in DONE.
- PL6_WAIT_FOR_TAPE held low forever:
  - Required response: FAULT (state 16, fault=1) exactly 50 ticks after WAIT_TT entry; all PWR_* at reset values.
- PL6_WAIT_FOR_TAPE falls during ATS_TT:
  - Required response: WAIT_TT exits one cycle after entry.
- abort asserted in OP with start on the same cycle:
  - Required response: next edge gives IDLE, PWR_OP=0, PWR_NO_OP=1, busy=0.
  - A later start restarts from CLEAR.
- rst asserted in NT:
  - Required response: next edge has all outputs at reset values and state_dbg=0.
  - A start issued while busy in a fresh run changes nothing.

Source files
------------

// File: rtl/g15_power_sequencer.sv
`default_nettype none
// =============================================================================
// g15_power_sequencer : timed power-up sequencer (CLEAR, ~OP/OP, ATS, NT, GO) for the G-15 core
// Rev 1.0
// =============================================================================
module g15_power_sequencer #(
  parameter int CNT_W              = 16,
  parameter int CLEAR_TICKS        = 150,
  parameter int NOOP_PRE_TICKS     = 30,
  parameter int OP_TICKS           = 60,
  parameter int NOOP_POST_TICKS    = 30,
  parameter int SETTLE_TICKS       = 120,
  parameter int ATS_TICKS          = 30,
  parameter int NT_TICKS           = 120,
  parameter int TAPE_TIMEOUT_TICKS = 60000
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       abort,
  input  logic       mode_warm,
  input  logic       mode_skip_tt,
  input  logic       mode_auto_go,
  input  logic       PL6_WAIT_FOR_TAPE,
  output logic       PWR_CLEAR,
  output logic       PWR_NO_CLEAR,
  output logic       PWR_OP,
  output logic       PWR_NO_OP,
  output logic       PWR_ATS,
  output logic       PWR_NT,
  output logic       SW_GO,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    S_IDLE      = 5'd0,  S_CLEAR    = 5'd1,  S_NOOP_PRE = 5'd2,  S_OP       = 5'd3,
    S_NOOP_POST = 5'd4,  S_SETTLE_A = 5'd5,  S_ATS_TT   = 5'd6,  S_WAIT_TT  = 5'd7,
    S_SETTLE_B  = 5'd8,  S_NT       = 5'd9,  S_SETTLE_C = 5'd10, S_ATS_LD   = 5'd11,
    S_WAIT_LD   = 5'd12, S_SETTLE_D = 5'd13, S_GO       = 5'd14, S_DONE     = 5'd15,
    S_FAULT     = 5'd16
  } state_t;

  state_t           state_q, state_d, out_state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             skip_q, auto_go_q, via_go_q, armed_q;
  logic             sync1_q, sync2_q, prev_q;
  logic             expired_d, fall_d, accept_d, out_go_d;

  function automatic logic [CNT_W-1:0] dur_of(input state_t s);
    case (s)
      S_CLEAR:                    dur_of = CNT_W'(CLEAR_TICKS);
      S_NOOP_PRE:                 dur_of = CNT_W'(NOOP_PRE_TICKS);
      S_OP:                       dur_of = CNT_W'(OP_TICKS);
      S_NOOP_POST:                dur_of = CNT_W'(NOOP_POST_TICKS);
      S_SETTLE_A, S_SETTLE_B,
      S_SETTLE_C, S_SETTLE_D:     dur_of = CNT_W'(SETTLE_TICKS);
      S_ATS_TT, S_ATS_LD:         dur_of = CNT_W'(ATS_TICKS);
      S_NT:                       dur_of = CNT_W'(NT_TICKS);
      S_WAIT_TT, S_WAIT_LD:       dur_of = CNT_W'(TAPE_TIMEOUT_TICKS);
      default:                    dur_of = '0;
    endcase
  endfunction

  always_comb begin
    // A loaded count of N expires on the Nth tick; a count of 0 expires at once.
    expired_d = (cnt_q == '0) || (tick && (cnt_q == CNT_W'(1)));
    fall_d    = prev_q & ~sync2_q;
    accept_d  = start && !abort &&
                (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAULT);
    state_d   = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: if (accept_d) state_d = mode_warm ? S_NOOP_PRE : S_CLEAR;
      S_CLEAR:     if (expired_d) state_d = S_NOOP_PRE;
      S_NOOP_PRE:  if (expired_d) state_d = S_OP;
      S_OP:        if (expired_d) state_d = S_NOOP_POST;
      S_NOOP_POST: if (expired_d) state_d = S_SETTLE_A;
      S_SETTLE_A:  if (expired_d) state_d = skip_q ? S_ATS_LD : S_ATS_TT;
      S_ATS_TT:    if (expired_d) state_d = S_WAIT_TT;
      S_WAIT_TT:   if (armed_q) state_d = S_SETTLE_B; else if (expired_d) state_d = S_FAULT;
      S_SETTLE_B:  if (expired_d) state_d = S_NT;
      S_NT:        if (expired_d) state_d = S_SETTLE_C;
      S_SETTLE_C:  if (expired_d) state_d = S_ATS_LD;
      S_ATS_LD:    if (expired_d) state_d = S_WAIT_LD;
      S_WAIT_LD:   if (armed_q) state_d = S_SETTLE_D; else if (expired_d) state_d = S_FAULT;
      S_SETTLE_D:  if (expired_d) state_d = auto_go_q ? S_GO : S_DONE;
      S_GO:        state_d = S_DONE;
      default:     state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;

    // Abort and restart-from-rest present idle outputs on the very edge they act.
    out_state_d = state_q;
    out_go_d    = via_go_q;
    if (abort || (accept_d && state_q != S_IDLE)) begin
      out_state_d = S_IDLE;
      out_go_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      skip_q       <= 1'b0;
      auto_go_q    <= 1'b0;
      via_go_q     <= 1'b0;
      armed_q      <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      PWR_CLEAR    <= 1'b0;
      PWR_NO_CLEAR <= 1'b1;
      PWR_OP       <= 1'b0;
      PWR_NO_OP    <= 1'b1;
      PWR_ATS      <= 1'b0;
      PWR_NT       <= 1'b0;
      SW_GO        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      state_dbg    <= '0;
    end else begin
      sync1_q <= PL6_WAIT_FOR_TAPE;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      if (state_d != state_q)
        cnt_q <= dur_of(state_d);
      else if (tick && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);
      if (accept_d) begin
        skip_q    <= mode_skip_tt;
        auto_go_q <= mode_auto_go;
      end
      // Edges before ATS belong to a previous block and are discarded here.
      if (state_d != state_q && (state_d == S_ATS_TT || state_d == S_ATS_LD))
        armed_q <= 1'b0;
      else if (fall_d)
        armed_q <= 1'b1;
      via_go_q     <= (state_d == S_DONE) && (state_q == S_GO || via_go_q);
      PWR_CLEAR    <= (out_state_d == S_CLEAR);
      PWR_NO_CLEAR <= (out_state_d != S_CLEAR);
      PWR_OP       <= (out_state_d == S_OP);
      PWR_NO_OP    <= !(out_state_d == S_NOOP_PRE || out_state_d == S_OP ||
                        out_state_d == S_NOOP_POST);
      PWR_ATS      <= (out_state_d == S_ATS_TT || out_state_d == S_ATS_LD);
      PWR_NT       <= (out_state_d == S_NT);
      SW_GO        <= (out_state_d == S_GO) || (out_state_d == S_DONE && out_go_d);
      busy         <= !(out_state_d == S_IDLE || out_state_d == S_DONE ||
                        out_state_d == S_FAULT);
      done         <= (out_state_d == S_DONE);
      fault        <= (out_state_d == S_FAULT);
      state_dbg    <= out_state_d;
    end
  end

endmodule
`default_nettype wire
